// File: rtl/clk_en_sched.sv
// clk_en_sched: four programmable tick dividers feeding a round-robin
// arbiter for one shared resource. Each channel counts down from its divide
// value. On expiry it raises a pending tick. A single grant per cycle is
// issued while ready is high. A tick that expires while the previous one is
// still waiting sets a sticky overrun flag.
module clk_en_sched #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       ch_en,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_sel,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic             ready,
   input  logic             ovr_clr,
   output logic [3:0]       gnt,
   output logic             gnt_valid,
   output logic [1:0]       gnt_id,
   output logic [3:0]       pend,
   output logic [3:0]       ovr
);

   logic [CNT_W-1:0] div_q [4];
   logic [CNT_W-1:0] div_d [4];
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];
   logic [3:0]       pend_q, pend_d;
   logic [3:0]       ovr_q, ovr_d;
   logic [1:0]       ptr_q, ptr_d;

   logic [3:0]       gnt_c;
   logic [1:0]       gnt_id_c;
   logic             gnt_valid_c;
   logic [3:0]       expire;
   logic [3:0]       wr_hit;

   // Round-robin pick: first pending channel at or after ptr, only while ready
   always_comb begin
      logic [1:0] idx;
      gnt_c       = '0;
      gnt_id_c    = '0;
      gnt_valid_c = 1'b0;
      idx         = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (ready && !gnt_valid_c && pend_q[idx]) begin
            gnt_c[idx]  = 1'b1;
            gnt_id_c    = idx;
            gnt_valid_c = 1'b1;
         end
      end
   end

   // Per-channel counter, pending and overrun next state
   always_comb begin
      pend_d = pend_q;
      ovr_d  = ovr_q & ~{4{ovr_clr}};
      expire = '0;
      wr_hit = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         div_d[i]  = div_q[i];
         cnt_d[i]  = cnt_q[i];
         wr_hit[i] = cfg_we && (cfg_sel == 2'(i));
         if (wr_hit[i]) begin
            // A config write wins over every other update and drops any
            // outstanding tick without flagging an overrun.
            div_d[i]  = cfg_div;
            cnt_d[i]  = cfg_div;
            pend_d[i] = 1'b0;
         end else if (!ch_en[i]) begin
            cnt_d[i]  = div_q[i];
            pend_d[i] = 1'b0;
         end else if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
            if (gnt_c[i]) begin
               pend_d[i] = 1'b0;
            end
         end else begin
            // Expiry re-arms pend even when this channel is being granted now,
            // so a back-to-back tick is kept rather than counted as overrun.
            cnt_d[i]  = div_q[i];
            expire[i] = 1'b1;
            pend_d[i] = 1'b1;
            if (pend_q[i] && !gnt_c[i]) begin
               ovr_d[i] = 1'b1;
            end
         end
      end
   end

   // Pointer advances past the channel just granted
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_valid_c) begin
         ptr_d = gnt_id_c + 2'd1;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 4; i++) begin
            div_q[i] <= '0;
            cnt_q[i] <= '0;
         end
         pend_q <= '0;
         ovr_q  <= '0;
         ptr_q  <= '0;
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            div_q[i] <= div_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         pend_q <= pend_d;
         ovr_q  <= ovr_d;
         ptr_q  <= ptr_d;
      end
   end

   assign gnt       = gnt_c;
   assign gnt_valid = gnt_valid_c;
   assign gnt_id    = gnt_id_c;
   assign pend      = pend_q;
   assign ovr       = ovr_q;

endmodule
